seg_instruction_fetch: RTL and testbench

Instruction-fetch pipeline segment of the MIPS datapath: owns the PC register and the instruction memory, and produces the IF/ID latch consumed by `seg_instruction_decode` (instruction word and PC+4). It supports stall and flush from downstream hazard/branch logic, continuous or single-step execution, and in-place program loading while idle. A dedicated HALT word stops fetching once it has been latched.

---
 rtl/mips_pkg.sv | 22 ++
 rtl/instruction_memory.sv | 35 +++
 rtl/seg_instruction_fetch.sv | 139 +++++++++++++
 tb/tb_seg_instruction_fetch.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared definitions for the MIPS datapath segments.
//   HALT_WORD  : instruction word that stops the fetch segment
//   NOP_WORD   : word loaded into IF/ID when it is squashed
//   PC_INC     : byte distance between consecutive instructions
//   fetch_state_t : fetch-segment FSM encoding
// -----------------------------------------------------------------------------
package mips_pkg;

  localparam logic [31:0] HALT_WORD = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP_WORD  = 32'h0000_0000;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_STEP   = 2'd2,
    ST_HALTED = 2'd3
  } fetch_state_t;

endpackage : mips_pkg

// File: rtl/instruction_memory.sv
// -----------------------------------------------------------------------------
// instruction_memory
// Word-addressed program store, 2^NB_ADDR x NB_DATA.
//   i_clk      : clock for the write port
//   i_wr_en    : write strobe
//   i_wr_addr  : write word address
//   i_wr_data  : write data
//   i_rd_addr  : read word address (asynchronous read)
//   o_rd_data  : word at i_rd_addr
// Contents are never cleared, so a program survives a datapath reset.
// -----------------------------------------------------------------------------
module instruction_memory #(
  parameter int NB_DATA = 32,
  parameter int NB_ADDR = 10
) (
  input  logic               i_clk,
  input  logic               i_wr_en,
  input  logic [NB_ADDR-1:0] i_wr_addr,
  input  logic [NB_DATA-1:0] i_wr_data,
  input  logic [NB_ADDR-1:0] i_rd_addr,
  output logic [NB_DATA-1:0] o_rd_data
);

  logic [NB_DATA-1:0] mem [2**NB_ADDR];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      mem[i_wr_addr] <= i_wr_data;
    end
  end

  // The fetch segment needs the word in the same cycle the PC is presented.
  assign o_rd_data = mem[i_rd_addr];

endmodule : instruction_memory

// File: rtl/seg_instruction_fetch.sv
// -----------------------------------------------------------------------------
// seg_instruction_fetch
// IF segment: PC register, instruction memory and IF/ID latch.
//   i_clk, i_rst      : clock, synchronous active-high reset
//   i_start           : leave IDLE (i_step_mode picks STEP or RUN)
//   i_step            : one fetch per high cycle while in STEP
//   i_stall           : hold PC and IF/ID
//   i_flush, i_target : redirect PC (word aligned) and squash IF/ID
//   i_load_*          : program load port, honoured only in IDLE
//   o_PC              : PC+4 of the instruction in IF/ID
//   o_instruction     : IF/ID instruction word
//   o_valid           : IF/ID holds a real instruction
//   o_pc_current      : PC register
//   o_halted          : HALT word has been fetched; only reset leaves
// -----------------------------------------------------------------------------
module seg_instruction_fetch
  import mips_pkg::*;
#(
  parameter int NB_INSTRUC = 32,
  parameter int NB_PC      = 32,
  parameter int NB_ADDR    = 10
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic                  i_step_mode,
  input  logic                  i_step,
  input  logic                  i_stall,
  input  logic                  i_flush,
  input  logic [NB_PC-1:0]      i_target,
  input  logic                  i_load_en,
  input  logic [NB_ADDR-1:0]    i_load_addr,
  input  logic [NB_INSTRUC-1:0] i_load_data,
  output logic [NB_PC-1:0]      o_PC,
  output logic [NB_INSTRUC-1:0] o_instruction,
  output logic                  o_valid,
  output logic [NB_PC-1:0]      o_pc_current,
  output logic                  o_halted
);

  localparam logic [NB_INSTRUC-1:0] HALT_W  = NB_INSTRUC'(HALT_WORD);
  localparam logic [NB_INSTRUC-1:0] NOP_W   = NB_INSTRUC'(NOP_WORD);
  localparam logic [NB_PC-1:0]      PC_STEP = NB_PC'(PC_INC);

  fetch_state_t          state_reg, state_next;
  logic [NB_PC-1:0]      pc_reg, pc_next;
  logic [NB_PC-1:0]      if_pc_reg, if_pc_next;
  logic [NB_INSTRUC-1:0] if_instr_reg, if_instr_next;
  logic                  if_valid_reg, if_valid_next;

  logic                  adv;
  logic                  mem_wr_en;
  logic [NB_INSTRUC-1:0] fetch_word;
  logic [NB_PC-1:0]      pc_plus4;

  instruction_memory #(
    .NB_DATA (NB_INSTRUC),
    .NB_ADDR (NB_ADDR)
  ) u_imem (
    .i_clk     (i_clk),
    .i_wr_en   (mem_wr_en),
    .i_wr_addr (i_load_addr),
    .i_wr_data (i_load_data),
    // Byte PC to word address; high bits alias beyond the memory depth.
    .i_rd_addr (pc_reg[NB_ADDR+1:2]),
    .o_rd_data (fetch_word)
  );

  assign pc_plus4 = pc_reg + PC_STEP;
  // HALTED is excluded simply because it is neither RUN nor STEP.
  assign adv = (state_reg == ST_RUN) || ((state_reg == ST_STEP) && i_step);

  always_comb begin
    state_next    = state_reg;
    pc_next       = pc_reg;
    if_pc_next    = if_pc_reg;
    if_instr_next = if_instr_reg;
    if_valid_next = if_valid_reg;
    mem_wr_en     = 1'b0;

    unique case (state_reg)
      ST_IDLE: begin
        mem_wr_en = i_load_en;
        if (i_start) begin
          state_next = i_step_mode ? ST_STEP : ST_RUN;
        end
      end
      ST_RUN, ST_STEP: begin
        if (adv) begin
          if (i_flush) begin
            // Flush beats stall: the stalled instruction is on the wrong path.
            pc_next       = {i_target[NB_PC-1:2], 2'b00};
            if_instr_next = NOP_W;
            if_pc_next    = '0;
            if_valid_next = 1'b0;
          end else if (!i_stall) begin
            if_instr_next = fetch_word;
            if_pc_next    = pc_plus4;
            if_valid_next = 1'b1;
            if (fetch_word == HALT_W) begin
              state_next = ST_HALTED;
            end else begin
              pc_next = pc_plus4;
            end
          end
        end
      end
      ST_HALTED: begin
        // Everything but reset is ignored; IF/ID keeps the HALT word.
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg    <= ST_IDLE;
      pc_reg       <= '0;
      if_pc_reg    <= '0;
      if_instr_reg <= NOP_W;
      if_valid_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      pc_reg       <= pc_next;
      if_pc_reg    <= if_pc_next;
      if_instr_reg <= if_instr_next;
      if_valid_reg <= if_valid_next;
    end
  end

  assign o_PC          = if_pc_reg;
  assign o_instruction = if_instr_reg;
  assign o_valid       = if_valid_reg;
  assign o_pc_current  = pc_reg;
  assign o_halted      = (state_reg == ST_HALTED);

endmodule : seg_instruction_fetch

// File: tb/tb_seg_instruction_fetch.sv
// -----------------------------------------------------------------------------
// tb_seg_instruction_fetch
// Table of per-cycle {inputs, expected IF outputs} rows applied one clock each,
// followed by a hand-written HALT-in-STEP sequence.
// -----------------------------------------------------------------------------
module tb_seg_instruction_fetch;

  localparam int NB_INSTRUC = 32;
  localparam int NB_PC      = 32;
  localparam int NB_ADDR    = 10;
  localparam logic [31:0] HALT = 32'hFFFF_FFFF;

  logic                  clk = 1'b0;
  logic                  rst, start, step_mode, step, stall, flush;
  logic [NB_PC-1:0]      target;
  logic                  load_en;
  logic [NB_ADDR-1:0]    load_addr;
  logic [NB_INSTRUC-1:0] load_data;
  logic [NB_PC-1:0]      o_pc;
  logic [NB_INSTRUC-1:0] o_instr;
  logic                  o_valid;
  logic [NB_PC-1:0]      o_pc_cur;
  logic                  o_halted;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  seg_instruction_fetch #(
    .NB_INSTRUC (NB_INSTRUC),
    .NB_PC      (NB_PC),
    .NB_ADDR    (NB_ADDR)
  ) dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_start       (start),
    .i_step_mode   (step_mode),
    .i_step        (step),
    .i_stall       (stall),
    .i_flush       (flush),
    .i_target      (target),
    .i_load_en     (load_en),
    .i_load_addr   (load_addr),
    .i_load_data   (load_data),
    .o_PC          (o_pc),
    .o_instruction (o_instr),
    .o_valid       (o_valid),
    .o_pc_current  (o_pc_cur),
    .o_halted      (o_halted)
  );

  typedef struct {
    logic        rst, start, mode, step, stall, flush;
    logic [31:0] target;
    logic        ld;
    logic [9:0]  la;
    logic [31:0] ldd;
    logic [31:0] e_ins, e_pc;
    logic        e_val;
    logic [31:0] e_pcc;
    logic        e_halt;
  } row_t;

  row_t tbl[$];

  function automatic row_t mk(
    input logic rst_i, start_i, mode_i, step_i, stall_i, flush_i,
    input logic [31:0] tgt_i,
    input logic ld_i, input logic [9:0] la_i, input logic [31:0] ldd_i,
    input logic [31:0] ins_i, pc_i, input logic val_i,
    input logic [31:0] pcc_i, input logic halt_i);
    row_t r;
    r.rst = rst_i; r.start = start_i; r.mode = mode_i; r.step = step_i;
    r.stall = stall_i; r.flush = flush_i; r.target = tgt_i;
    r.ld = ld_i; r.la = la_i; r.ldd = ldd_i;
    r.e_ins = ins_i; r.e_pc = pc_i; r.e_val = val_i;
    r.e_pcc = pcc_i; r.e_halt = halt_i;
    return r;
  endfunction

  // Program B word at index i.
  function automatic logic [31:0] w(input int i);
    return 32'h1000_0000 + 32'(i);
  endfunction

  task automatic chk(input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s row %0d: got %h expected %h", name, idx, act, exp);
    end
  endtask

  task automatic apply(input row_t r, input int idx);
    rst = r.rst; start = r.start; step_mode = r.mode; step = r.step;
    stall = r.stall; flush = r.flush; target = r.target;
    load_en = r.ld; load_addr = r.la; load_data = r.ldd;
    @(posedge clk);
    #1;
    chk("instruction", idx, o_instr, r.e_ins);
    chk("o_PC",        idx, o_pc, r.e_pc);
    chk("valid",       idx, {31'd0, o_valid}, {31'd0, r.e_val});
    chk("pc_current",  idx, o_pc_cur, r.e_pcc);
    chk("halted",      idx, {31'd0, o_halted}, {31'd0, r.e_halt});
    $display("row %0d: ins=%h pc=%h v=%0b pcc=%h h=%0b",
             idx, o_instr, o_pc, o_valid, o_pc_cur, o_halted);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; step_mode = 1'b0; step = 1'b0;
    stall = 1'b0; flush = 1'b0; target = '0;
    load_en = 1'b0; load_addr = '0; load_data = '0;

    //            rst st md sp sl fl target         ld la   ldd           ins           o_PC          v  pc_cur        h
    // Phase A: load, RUN, HALT
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,            0, 0,   0,            0,            0,            0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 0,   32'h2001_0005, 0,           0,            0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 1,   32'h2002_0007, 0,           0,            0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 2,   HALT,         0,            0,            0, 0,            0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,            0, 0,   0,            0,            0,            0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            32'h2001_0005, 4,           1, 4,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            32'h2002_0007, 8,           1, 8,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            HALT,         12,           1, 8,            1));
    tbl.push_back(mk(0, 1, 0, 1, 1, 1, 32'h40,       0, 0,   0,            HALT,         12,           1, 8,            1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 2,   32'h0,        HALT,         12,           1, 8,            1));
    // Phase B: stall, flush priority, load ignored in RUN, aliasing, reset
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,            0, 0,   0,            0,            0,            0, 0,            0));
    for (int i = 0; i < 8; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,          1, 10'(i), w(i),      0,            0,            0, 0,            0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,            0, 0,   0,            0,            0,            0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            w(0),         4,            1, 4,            0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,            0, 0,   0,            w(0),         4,            1, 4,            0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 0, 0,            0, 0,   0,            w(0),         4,            1, 4,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            w(1),         8,            1, 8,            0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 1, 32'h13,       0, 0,   0,            0,            0,            0, 32'h10,       0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            w(4),         32'h14,       1, 32'h14,       0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            1, 0,   32'h1234_5678, w(5),        32'h18,       1, 32'h18,       0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 1, 32'h1003,     0, 0,   0,            0,            0,            0, 32'h1000,     0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            w(0),         32'h1004,     1, 32'h1004,     0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,            0, 0,   0,            0,            0,            0, 0,            0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0,            0, 0,   0,            0,            0,            0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            w(0),         4,            1, 4,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            w(1),         8,            1, 8,            0));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0,            0, 0,   0,            0,            0,            0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            0,            0,            0, 0,            0));
    // Phase C: STEP mode
    tbl.push_back(mk(0, 1, 1, 0, 0, 0, 0,            0, 0,   0,            0,            0,            0, 0,            0));
    for (int i = 0; i < 5; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,          0, 0,   0,            0,            0,            0, 0,            0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,            0, 0,   0,            w(0),         4,            1, 4,            0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0,            0, 0,   0,            w(0),         4,            1, 4,            0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,            0, 0,   0,            w(1),         8,            1, 8,            0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,            0, 0,   0,            w(2),         12,           1, 12,           0));
    tbl.push_back(mk(0, 0, 0, 1, 1, 0, 0,            0, 0,   0,            w(2),         12,           1, 12,           0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 1, 32'h1C,       0, 0,   0,            0,            0,            0, 32'h1C,       0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0,            0, 0,   0,            w(7),         32'h20,       1, 32'h20,       0));

    for (int i = 0; i < tbl.size(); i++) apply(tbl[i], i);

    // Hand-written: HALT reached in STEP mode, then everything but reset ignored.
    apply(mk(1, 0, 0, 0, 0, 0, 0,        0, 0, 0,        0,    0, 0, 0, 0), 100);
    apply(mk(0, 0, 0, 0, 0, 0, 0,        1, 1, HALT,     0,    0, 0, 0, 0), 101);
    apply(mk(0, 1, 1, 0, 0, 0, 0,        0, 0, 0,        0,    0, 0, 0, 0), 102);
    apply(mk(0, 0, 0, 1, 0, 0, 0,        0, 0, 0,        w(0), 4, 1, 4, 0), 103);
    apply(mk(0, 0, 0, 1, 0, 0, 0,        0, 0, 0,        HALT, 8, 1, 4, 1), 104);
    apply(mk(0, 1, 0, 1, 0, 1, 32'h40,   0, 0, 0,        HALT, 8, 1, 4, 1), 105);
    apply(mk(0, 0, 0, 1, 0, 0, 0,        1, 0, 32'hABCD, HALT, 8, 1, 4, 1), 106);
    apply(mk(1, 0, 0, 0, 0, 0, 0,        0, 0, 0,        0,    0, 0, 0, 0), 107);
    // Halted-state load above must not have landed: word 0 is still w(0).
    apply(mk(0, 1, 0, 0, 0, 0, 0,        0, 0, 0,        0,    0, 0, 0, 0), 108);
    apply(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 0,        w(0), 4, 1, 4, 0), 109);
    apply(mk(0, 0, 0, 0, 0, 0, 0,        0, 0, 0,        HALT, 8, 1, 4, 1), 110);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_seg_instruction_fetch
